ctrl_wr_bram: RTL and testbench

Output-side counterpart of the BRAM read controller. Pops processed bytes from the outbound FIFO and packs them little-endian into 32-bit words (byte 0 in [7:0]). Writes each packed word to the result BRAM at consecutive word addresses. Signals finish once data_size bytes are stored.

---
 rtl/stega_pkg.sv | 19 +
 rtl/ctrl_wr_bram_byte_packer.sv | 57 +++++
 rtl/ctrl_wr_bram.sv | 155 +++++++++++++++
 tb/tb_ctrl_wr_bram.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stega_pkg.sv
// Shared constants and FSM state encoding for the BRAM write-side controller.
package stega_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdFf   = 3'd1,
        StWaitFf = 3'd2,
        StLatch  = 3'd3,
        StWrBram = 3'd4,
        StWrDone = 3'd5,
        StFinish = 3'd6
    } state_e;

endpackage

// File: rtl/ctrl_wr_bram_byte_packer.sv
// Little-endian byte-to-word packer: lane counter, word register and write-mask generation.
// Define WR_PARTIAL_MASK_EN to mask off unused lanes of a trailing partial word.
module ctrl_wr_bram_byte_packer
    import stega_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [BYTE_W-1:0]         byte_i,
    output logic                      full_o,
    output logic [WORD_W-1:0]         word_o,
    output logic [BYTES_PER_WORD-1:0] mask_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (clear_i) begin
            lane_d = '0;
            word_d = '0;
        end else if (load_i) begin
            word_d[lane_q*BYTE_W +: BYTE_W] = byte_i;
            lane_d                          = lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    assign full_o = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word_o = word_q;

`ifdef WR_PARTIAL_MASK_EN
    // Lane counter wraps to 0 after a complete word, which means all lanes are valid.
    always_comb begin
        if (lane_q == '0) begin
            mask_o = '1;
        end else begin
            mask_o = BYTES_PER_WORD'((1 << lane_q) - 1);
        end
    end
`else
    assign mask_o = '1;
`endif

endmodule

// File: rtl/ctrl_wr_bram.sv
// Pops bytes from the outbound FIFO, packs them into 32-bit words and writes them to the result
// BRAM. Partial-word lane masking is enabled by defining WR_PARTIAL_MASK_EN.
module ctrl_wr_bram
    import stega_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_BYTES  = DATA_WIDTH / 8,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned FF_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [REG_WIDTH-1:0]  data_size_i,
    output logic                  finish_o,
    input  logic                  ff_empty_i,
    output logic                  ff_rden_o,
    input  logic [FF_WIDTH-1:0]   ff_rd_data_i,
    output logic                  bram_clk_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wrdata_o,
    output logic [NUM_BYTES-1:0]  we_o
);

    state_e                  state_q, state_d;
    logic [REG_WIDTH-1:0]    size_q, size_d;
    logic [REG_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;
    logic [REG_WIDTH-1:0]    word_idx_q, word_idx_d;
    logic                    finish_q, finish_d;
    logic                    ff_rden_q, ff_rden_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
    logic [NUM_BYTES-1:0]    we_q, we_d;

    logic                      pk_clear;
    logic                      pk_load;
    logic                      pk_full;
    logic [WORD_W-1:0]         pk_word;
    logic [BYTES_PER_WORD-1:0] pk_mask;

    ctrl_wr_bram_byte_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (pk_clear),
        .load_i  (pk_load),
        .byte_i  (BYTE_W'(ff_rd_data_i)),
        .full_o  (pk_full),
        .word_o  (pk_word),
        .mask_o  (pk_mask)
    );

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        finish_d   = finish_q;
        ff_rden_d  = 1'b0;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        we_d       = we_q;
        pk_clear   = 1'b0;
        pk_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                byte_cnt_d = '0;
                word_idx_d = '0;
                pk_clear   = 1'b1;
                finish_d   = 1'b0;
                if (start_i && (data_size_i != '0)) begin
                    size_d  = data_size_i;
                    state_d = StRdFf;
                end
            end
            StRdFf: begin
                if (byte_cnt_q >= size_q) begin
                    state_d = StFinish;
                end else if (!ff_empty_i) begin
                    ff_rden_d = 1'b1;
                    state_d   = StWaitFf;
                end
            end
            StWaitFf: begin
                state_d = StLatch;
            end
            StLatch: begin
                pk_load    = 1'b1;
                byte_cnt_d = byte_cnt_q + REG_WIDTH'(1);
                if (pk_full || (byte_cnt_q + REG_WIDTH'(1) == size_q)) begin
                    state_d = StWrBram;
                end else begin
                    state_d = StRdFf;
                end
            end
            StWrBram: begin
                addr_d   = ADDR_WIDTH'({word_idx_q, 2'b00});
                wrdata_d = DATA_WIDTH'(pk_word);
                we_d     = NUM_BYTES'(pk_mask);
                state_d  = StWrDone;
            end
            StWrDone: begin
                we_d       = '0;
                word_idx_d = word_idx_q + REG_WIDTH'(1);
                pk_clear   = 1'b1;
                state_d    = StRdFf;
            end
            StFinish: begin
                // Hold finish until the host drops start, then rearm.
                if (start_i) begin
                    finish_d = 1'b1;
                end else begin
                    finish_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            size_q     <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            finish_q   <= 1'b0;
            ff_rden_q  <= 1'b0;
            addr_q     <= '0;
            wrdata_q   <= '0;
            we_q       <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            finish_q   <= finish_d;
            ff_rden_q  <= ff_rden_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            we_q       <= we_d;
        end
    end

    assign bram_clk_o = clk;
    assign finish_o   = finish_q;
    assign ff_rden_o  = ff_rden_q;
    assign addr_o     = addr_q;
    assign wrdata_o   = wrdata_q;
    assign we_o       = we_q;

endmodule

// File: tb/tb_ctrl_wr_bram.sv
// Self-checking bench for ctrl_wr_bram: FIFO model, BRAM write monitor and a word-level model.
module tb_ctrl_wr_bram;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic [31:0] data_size  = '0;
    logic        ff_empty   = 1'b1;
    logic [7:0]  ff_rd_data = '0;
    logic        finish;
    logic        ff_rden;
    logic        bram_clk;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [3:0]  we;

    ctrl_wr_bram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .data_size_i  (data_size),
        .finish_o     (finish),
        .ff_empty_i   (ff_empty),
        .ff_rden_o    (ff_rden),
        .ff_rd_data_i (ff_rd_data),
        .bram_clk_o   (bram_clk),
        .addr_o       (addr),
        .wrdata_o     (wrdata),
        .we_o         (we)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } wr_t;

    logic [7:0] mem [1024];
    int         wr_ptr     = 0;
    int         rd_ptr     = 0;
    int         rden_cnt   = 0;
    logic       hold_empty = 1'b0;
    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] cur_bytes [64];

    // FIFO with registered read and BRAM write monitor, both sampled mid-cycle.
    always @(negedge clk) begin
        if (ff_rden) begin
            if (rd_ptr != wr_ptr) begin
                ff_rd_data = mem[rd_ptr % 1024];
                rd_ptr++;
            end
            rden_cnt++;
        end
        if (we != 4'h0) got_q.push_back('{addr: addr, data: wrdata, we: we});
        ff_empty = hold_empty || (rd_ptr == wr_ptr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            mem[wr_ptr % 1024] = cur_bytes[i];
            wr_ptr++;
        end
    endtask

    // Expected writes straight from the byte stream: word w holds bytes 4w..4w+3, LSB first.
    task automatic build_exp(input int n);
        exp_q.delete();
        for (int w = 0; w * 4 < n; w++) begin
            int          cnt;
            logic [31:0] d;
            logic [3:0]  m;
            cnt = (n - 4 * w > 4) ? 4 : n - 4 * w;
            d   = '0;
            for (int k = 0; k < cnt; k++) d[k*8 +: 8] = cur_bytes[4 * w + k];
`ifdef WR_PARTIAL_MASK_EN
            m = 4'((1 << cnt) - 1);
`else
            m = 4'hF;
`endif
            exp_q.push_back('{addr: 32'(4 * w), data: d, we: m});
        end
    endtask

    task automatic compare_writes(input int gbase);
        int ngot;
        ngot = got_q.size() - gbase;
        check("num_writes", 64'(ngot), 64'(exp_q.size()));
        for (int i = 0; i < ngot && i < exp_q.size(); i++) begin
            check($sformatf("wr%0d_addr", i), 64'(got_q[gbase + i].addr), 64'(exp_q[i].addr));
            check($sformatf("wr%0d_data", i), 64'(got_q[gbase + i].data), 64'(exp_q[i].data));
            check($sformatf("wr%0d_we", i), 64'(got_q[gbase + i].we), 64'(exp_q[i].we));
        end
    endtask

    task automatic wait_finish(input int bound, input bit stall_rand);
        bit done;
        done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            @(posedge clk); #1;
            if (stall_rand) hold_empty = ($urandom_range(0, 3) == 0);
            if (finish === 1'b1) done = 1'b1;
        end
        hold_empty = 1'b0;
        check("finish_seen", 64'(done), 64'd1);
    endtask

    // Finish must hold while start is high and drop the cycle after start falls.
    task automatic end_xfer();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("finish_hold", 64'(finish), 64'd1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("finish_clr", 64'(finish), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_xfer(input int n, input bit stall_rand);
        int gbase;
        int rbase;
        gbase = got_q.size();
        rbase = rden_cnt;
        feed(0, n);
        build_exp(n);
        data_size = 32'(n);
        start     = 1'b1;
        wait_finish(60 * n + 100, stall_rand);
        compare_writes(gbase);
        check("rden_count", 64'(rden_cnt - rbase), 64'(n));
        end_xfer();
    endtask

    initial begin
        int gbase;
        int rbase;
        int n;
        int viol_fin;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_rden", 64'(ff_rden), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wrdata", 64'(wrdata), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("bram_clk", 64'(bram_clk), 64'(clk));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Eight bytes 0x11..0x88: two full words.
        for (int i = 0; i < 8; i++) cur_bytes[i] = 8'(8'h11 * (i + 1));
        gbase = got_q.size();
        run_xfer(8, 1'b0);
        if (got_q.size() >= gbase + 2) begin
            check("tp1_word0", 64'(got_q[gbase].data), 64'h44332211);
            check("tp1_word1", 64'(got_q[gbase + 1].data), 64'h88776655);
        end

        // Five bytes: trailing partial word.
        for (int i = 0; i < 5; i++) cur_bytes[i] = 8'(8'hA0 + i);
        run_xfer(5, 1'b0);

        // Reset after two of four bytes: partial word is discarded.
        for (int i = 0; i < 4; i++) cur_bytes[i] = 8'(8'hD0 + i);
        gbase = got_q.size();
        rbase = rden_cnt;
        feed(0, 4);
        data_size = 32'd4;
        start     = 1'b1;
        for (int c = 0; c < 40 && (rden_cnt - rbase) < 2; c++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_finish", 64'(finish), 64'd0);
        check("mid_rst_rden", 64'(ff_rden), 64'd0);
        check("mid_rst_addr", 64'(addr), 64'd0);
        check("mid_rst_wrdata", 64'(wrdata), 64'd0);
        check("mid_rst_we", 64'(we), 64'd0);
        check("mid_rst_nowr", 64'(got_q.size() - gbase), 64'd0);
        wr_ptr = rd_ptr;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) cur_bytes[i] = 8'(8'hE0 + i);
        run_xfer(4, 1'b0);

        // FIFO empty for 10 cycles after the second byte.
        for (int i = 0; i < 4; i++) cur_bytes[i] = 8'(8'hC0 + i);
        build_exp(4);
        gbase = got_q.size();
        rbase = rden_cnt;
        feed(0, 2);
        data_size = 32'd4;
        start     = 1'b1;
        for (int c = 0; c < 40 && (rden_cnt - rbase) < 2; c++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        hold_empty = 1'b1;
        feed(2, 4);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("stall_rden", 64'(ff_rden), 64'd0);
        end
        check("stall_nowr", 64'(got_q.size() - gbase), 64'd0);
        check("stall_rden_cnt", 64'(rden_cnt - rbase), 64'd2);
        hold_empty = 1'b0;
        wait_finish(200, 1'b0);
        compare_writes(gbase);
        end_xfer();

        // data_size = 0 must be ignored.
        gbase     = got_q.size();
        rbase     = rden_cnt;
        viol_fin  = 0;
        data_size = 32'd0;
        start     = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (finish !== 1'b0) viol_fin++;
        end
        check("sz0_finish", 64'(viol_fin), 64'd0);
        check("sz0_rden", 64'(rden_cnt - rbase), 64'd0);
        check("sz0_we", 64'(got_q.size() - gbase), 64'd0);
        start = 1'b0;
        @(posedge clk); #1;

        // Re-issue after a completed handshake: single word at address 0.
        for (int i = 0; i < 4; i++) cur_bytes[i] = 8'($urandom);
        run_xfer(4, 1'b0);

        // Random lengths and bytes with random FIFO starvation.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 13);
            for (int i = 0; i < n; i++) cur_bytes[i] = 8'($urandom);
            run_xfer(n, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
